piece_commit_ctrl: RTL and testbench
====================================

Name: piece_commit_ctrl

Overview:
- Downstream consumer of the test-position stage.
- Each frame it judges the proposed position/rotation and its collision flag: it accepts the move, rejects it, or locks the piece into the board.
- After a lock it scans and clears full rows, spawns the next piece and detects game over.
- It owns cur_pos/cur_rot/cur_piece, fallen_pieces, timer, drop_mode and the key handshake signals that feed the test-position stage.

Parameters:
- BOARD_W, 10, board columns.
- BOARD_H, 22, board rows; fallen_pieces bit index = y*BOARD_W + x. Port widths are fixed for the defaults.
- SPAWN_X, 4, spawn column.
- NUM_PIECES, 7, piece codes 0..NUM_PIECES-1.

Ports:
- frame_clk  in  1  single clock, one tick per frame.
- Reset  in  1  synchronous, active-low reset (sampled on frame_clk; 0 = reset).
- keycode  in  8  current key.
- test_pos_x  in  4  proposed x.
- test_pos_y  in  5  proposed y.
- test_rot  in  2  proposed rotation.
- test_intersects  in  1  proposed blocks overlap fallen_pieces.
- test_width  in  3  proposed piece width.
- test_height  in  3  proposed piece height.
- test_drop_mode  in  1  hard-drop request.
- cur_blk_1..cur_blk_4  in  8 each  board indices of the current piece at cur_pos/cur_rot (external block-position calculator).
- cur_pos_x  out  4.
- cur_pos_y  out  5.
- cur_rot  out  2.
- cur_piece  out  3.
- fallen_pieces  out  220  locked-cell map.
- timer  out  3  gravity counter.
- drop_mode  out  1.
- last_keycode  out  8.
- key_action_taken  out  1.
- lines_cleared  out  16  saturating total.
- game_over  out  1.

Behaviour:
- Reset (Reset==0 at a frame_clk edge) forces, on that edge:
  - state=SPAWN;
  - all cur_* outputs, timer, drop_mode, key_action_taken, lines_cleared and game_over = 0;
  - fallen_pieces = 0;
  - last_keycode = 0;
  - piece generator = 0.
- Reset overrides every state, including CLEAR mid-scan.
- States: SPAWN, CHECK, ACTIVE, LOCK, CLEAR, GAMEOVER.
- SPAWN, 1 cycle:
  - cur_piece <= generator;
  - cur_pos_x <= SPAWN_X, cur_pos_y <= 0, cur_rot <= 0;
  - timer <= 0, drop_mode <= 0;
  - generator advances modulo NUM_PIECES (6 -> 0);
  - next state CHECK.
- CHECK, 1 cycle, with cur_blk_* now valid for the new piece:
  - if any fallen_pieces[cur_blk_k] is set, go to GAMEOVER;
  - otherwise set stale and go to ACTIVE.
  - Any index >= 220 reads as empty.
- ACTIVE, every cycle:
  - last_keycode <= keycode; timer <= timer+1, wrapping 7 -> 0.
  - A stale flag is set on any cur_* change. While stale is set, the test inputs lag by one cycle, so they are ignored; stale clears and key_action_taken <= 0.
  - Otherwise evaluate in priority order:
    1. Down attempt (test_pos_y != cur_pos_y):
       - blocked if test_intersects==1 or test_pos_y==0 (upstream bottom wrap) -> LOCK;
       - else cur_pos_y <= test_pos_y and drop_mode <= test_drop_mode.
       - Lateral and rotate fields are ignored this cycle.
    2. Lateral/rotate attempt (test_pos_x != cur_pos_x or test_rot != cur_rot):
       - accepted only if !test_intersects, test_pos_x+test_width <= BOARD_W and cur_pos_y+test_height <= BOARD_H (4-bit/5-bit sums widened to avoid overflow);
       - on accept, cur_pos_x/cur_rot take the test values and key_action_taken <= 1 for exactly one cycle;
       - on reject, no change and key_action_taken <= 0.
    3. Otherwise: drop_mode <= test_drop_mode; no other change.
  - Every accept sets stale.
- LOCK, 1 cycle:
  - fallen_pieces[cur_blk_k] <= 1 for k=1..4; indices >= 220 are dropped;
  - drop_mode <= 0, row pointer r <= BOARD_H-1;
  - next state CLEAR.
- CLEAR, one row per cycle:
  - If row r is all ones: rows r..1 take rows r-1..0, row 0 becomes zero, r is held (rescan), and lines_cleared increments, saturating at 16'hFFFF.
  - Otherwise, if r==0 go to SPAWN; else r <= r-1.
  - Worst case is 22 rows plus 4 rescans = 26 cycles.
- GAMEOVER:
  - game_over=1;
  - all other outputs are held, apart from last_keycode, which still tracks keycode;
  - the state is left only by reset.
- Simultaneous down-block and lateral move in the same cycle: lock wins and the lateral move is discarded.

Test Plan:
- Reset held low 3 cycles, then released -> SPAWN, CHECK, ACTIVE on successive cycles; cur_piece=0, cur_pos_x=4, cur_pos_y=0, fallen_pieces=0, game_over=0.
- In ACTIVE, non-stale, test_pos_x=3, cur_pos_x=4, test_intersects=0, test_width=2 -> next cycle cur_pos_x=3 and key_action_taken=1 for one cycle; the following cycle's test inputs are ignored.
- test_pos_x=9, test_width=2 (sum 11 > 10) -> rejected; cur_pos_x unchanged, key_action_taken=0.
- cur_pos_y=5, test_pos_y=6, test_intersects=1, with cur_blk_1..4=60,61,62,63 -> LOCK; bits 60..63 set; CLEAR runs 22 cycles; then SPAWN with cur_piece=1.
- Preload row 21 (bits 210..219) complete apart from bit 219, with a lock supplying 219 -> row 21 is cleared, rows shift down, lines_cleared=1, and row 21 is rescanned before r decrements.
- Preload bit 44 set, with cur_blk_1=44 at spawn -> CHECK goes to GAMEOVER; game_over=1 is held until Reset is driven low for one cycle.

Source files
------------

// File: rtl/piece_commit_ctrl.sv
// piece_commit_ctrl: judges proposed moves, locks pieces, clears full rows, spawns and detects game over
module piece_commit_ctrl #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 22,
  parameter int SPAWN_X    = 4,
  parameter int NUM_PIECES = 7
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [7:0]                 keycode,
  input  logic [3:0]                 test_pos_x,
  input  logic [4:0]                 test_pos_y,
  input  logic [1:0]                 test_rot,
  input  logic                       test_intersects,
  input  logic [2:0]                 test_width,
  input  logic [2:0]                 test_height,
  input  logic                       test_drop_mode,
  input  logic [7:0]                 cur_blk_1,
  input  logic [7:0]                 cur_blk_2,
  input  logic [7:0]                 cur_blk_3,
  input  logic [7:0]                 cur_blk_4,
  output logic [3:0]                 cur_pos_x,
  output logic [4:0]                 cur_pos_y,
  output logic [1:0]                 cur_rot,
  output logic [2:0]                 cur_piece,
  output logic [BOARD_W*BOARD_H-1:0] fallen_pieces,
  output logic [2:0]                 timer,
  output logic                       drop_mode,
  output logic [7:0]                 last_keycode,
  output logic                       key_action_taken,
  output logic [15:0]                lines_cleared,
  output logic                       game_over
);
  localparam int N = BOARD_W * BOARD_H;
  typedef enum logic [2:0] {SPAWN, CHECK, ACTIVE, LOCK, CLEAR, GAMEOVER} state_t;
  state_t state, state_n;
  logic [4:0] r, r_n, cur_pos_y_n;
  logic [2:0] gen, gen_n, cur_piece_n, timer_n;
  logic [3:0] cur_pos_x_n;
  logic [1:0] cur_rot_n;
  logic [N-1:0] fallen_n;
  logic [7:0] last_keycode_n;
  logic [15:0] lines_cleared_n;
  logic stale, stale_n, drop_mode_n, kat_n, fits, hit;
  logic [7:0] blk [4];
  logic [BOARD_W-1:0] row;
  assign blk = '{cur_blk_1, cur_blk_2, cur_blk_3, cur_blk_4};
  assign game_over = state == GAMEOVER;
  assign row = fallen_pieces[r*BOARD_W +: BOARD_W];
  assign fits = !test_intersects && ({1'b0, test_pos_x} + 5'(test_width)) <= 5'(BOARD_W)
             && ({1'b0, cur_pos_y} + 6'(test_height)) <= 6'(BOARD_H);
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < 4; k++)
      hit = hit | (blk[k] < 8'(N) ? fallen_pieces[blk[k]] : 1'b0);
  end
  always_comb begin
    state_n = state;
    r_n = r;
    gen_n = gen;
    stale_n = stale;
    cur_pos_x_n = cur_pos_x;
    cur_pos_y_n = cur_pos_y;
    cur_rot_n = cur_rot;
    cur_piece_n = cur_piece;
    fallen_n = fallen_pieces;
    timer_n = timer;
    drop_mode_n = drop_mode;
    last_keycode_n = last_keycode;
    kat_n = key_action_taken;
    lines_cleared_n = lines_cleared;
    case (state)
      SPAWN: begin
        cur_piece_n = gen;
        cur_pos_x_n = 4'(SPAWN_X);
        cur_pos_y_n = '0;
        cur_rot_n = '0;
        timer_n = '0;
        drop_mode_n = 1'b0;
        gen_n = gen == 3'(NUM_PIECES - 1) ? '0 : gen + 3'd1;
        state_n = CHECK;
      end
      CHECK: begin
        stale_n = 1'b1;
        state_n = hit ? GAMEOVER : ACTIVE;
      end
      ACTIVE: begin
        last_keycode_n = keycode;
        timer_n = timer + 3'd1;
        kat_n = 1'b0;
        stale_n = 1'b0;
        if (stale) begin
        end else if (test_pos_y != cur_pos_y) begin
          // a blocked fall (or the upstream wrap to row 0) ends the piece's life
          if (test_intersects || test_pos_y == '0) state_n = LOCK;
          else begin
            cur_pos_y_n = test_pos_y;
            drop_mode_n = test_drop_mode;
            stale_n = 1'b1;
          end
        end else if (test_pos_x != cur_pos_x || test_rot != cur_rot) begin
          cur_pos_x_n = fits ? test_pos_x : cur_pos_x;
          cur_rot_n = fits ? test_rot : cur_rot;
          kat_n = fits;
          stale_n = fits;
        end else drop_mode_n = test_drop_mode;
      end
      LOCK: begin
        for (int k = 0; k < 4; k++)
          if (blk[k] < 8'(N)) fallen_n[blk[k]] = 1'b1;
        drop_mode_n = 1'b0;
        r_n = 5'(BOARD_H - 1);
        state_n = CLEAR;
      end
      CLEAR: begin
        // a full row collapses everything above it; r stays to rescan the row dropped in
        if (&row) begin
          for (int i = 1; i < BOARD_H; i++)
            if (5'(i) <= r) fallen_n[i*BOARD_W +: BOARD_W] = fallen_pieces[(i-1)*BOARD_W +: BOARD_W];
          fallen_n[BOARD_W-1:0] = '0;
          lines_cleared_n = &lines_cleared ? lines_cleared : lines_cleared + 16'd1;
        end else if (r == '0) state_n = SPAWN;
        else r_n = r - 5'd1;
      end
      GAMEOVER: last_keycode_n = keycode;
      default: state_n = SPAWN;
    endcase
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state <= SPAWN;
      r <= '0;
      gen <= '0;
      stale <= 1'b0;
      cur_pos_x <= '0;
      cur_pos_y <= '0;
      cur_rot <= '0;
      cur_piece <= '0;
      fallen_pieces <= '0;
      timer <= '0;
      drop_mode <= 1'b0;
      last_keycode <= '0;
      key_action_taken <= 1'b0;
      lines_cleared <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      gen <= gen_n;
      stale <= stale_n;
      cur_pos_x <= cur_pos_x_n;
      cur_pos_y <= cur_pos_y_n;
      cur_rot <= cur_rot_n;
      cur_piece <= cur_piece_n;
      fallen_pieces <= fallen_n;
      timer <= timer_n;
      drop_mode <= drop_mode_n;
      last_keycode <= last_keycode_n;
      key_action_taken <= kat_n;
      lines_cleared <= lines_cleared_n;
    end
  end
endmodule

// File: tb/tb_piece_commit_ctrl.sv
// tb_piece_commit_ctrl: directed test-plan scenarios plus random play against a board-level reference model
module tb_piece_commit_ctrl;
  localparam int P_SPAWN = 0, P_CHECK = 1, P_ACT = 2, P_LOCK = 3, P_CLEAR = 4, P_OVER = 5;
  logic frame_clk = 0, Reset = 0, ti = 0, td = 0;
  logic [7:0] keycode = 0, b1 = 8'hFF, b2 = 8'hFF, b3 = 8'hFF, b4 = 8'hFF;
  logic [3:0] tx = 4;
  logic [4:0] ty = 0;
  logic [1:0] tr = 0;
  logic [2:0] tw = 1, th = 1;
  logic [3:0] cur_pos_x;
  logic [4:0] cur_pos_y;
  logic [1:0] cur_rot;
  logic [2:0] cur_piece, timer;
  logic [219:0] fallen_pieces;
  logic drop_mode, key_action_taken, game_over;
  logic [7:0] last_keycode;
  logic [15:0] lines_cleared;
  int tests = 0, fails = 0;
  int m_ph, m_x, m_y, m_rot, m_piece, m_timer, m_drop, m_key, m_kat, m_lines, m_gen, m_stale, m_left;
  bit m_board [220];

  piece_commit_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .test_pos_x(tx), .test_pos_y(ty),
    .test_rot(tr), .test_intersects(ti), .test_width(tw), .test_height(th), .test_drop_mode(td),
    .cur_blk_1(b1), .cur_blk_2(b2), .cur_blk_3(b3), .cur_blk_4(b4),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_rot(cur_rot), .cur_piece(cur_piece),
    .fallen_pieces(fallen_pieces), .timer(timer), .drop_mode(drop_mode), .last_keycode(last_keycode),
    .key_action_taken(key_action_taken), .lines_cleared(lines_cleared), .game_over(game_over));

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [219:0] got, input logic [219:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [219:0] packed_board();
    logic [219:0] v;
    for (int i = 0; i < 220; i++) v[i] = m_board[i];
    return v;
  endfunction

  function automatic bit occ(input int i);
    return i < 220 && m_board[i];
  endfunction

  // lock cells, then compute the final board directly: full rows vanish, the rest settle downward
  task automatic model_lock();
    bit nb [220];
    int dst = 21, n = 0;
    bit full;
    int bl [4] = '{int'(b1), int'(b2), int'(b3), int'(b4)};
    foreach (bl[k]) if (bl[k] < 220) m_board[bl[k]] = 1;
    foreach (nb[i]) nb[i] = 0;
    for (int src = 21; src >= 0; src--) begin
      full = 1;
      for (int c = 0; c < 10; c++) full &= m_board[src*10 + c];
      if (full) n++;
      else begin
        for (int c = 0; c < 10; c++) nb[dst*10 + c] = m_board[src*10 + c];
        dst--;
      end
    end
    m_board = nb;
    m_lines = m_lines + n > 65535 ? 65535 : m_lines + n;
    m_left = 22 + n;
    m_drop = 0;
    m_ph = P_CLEAR;
  endtask

  task automatic model_step();
    if (!Reset) begin
      m_ph = P_SPAWN; m_x = 0; m_y = 0; m_rot = 0; m_piece = 0; m_timer = 0; m_drop = 0;
      m_key = 0; m_kat = 0; m_lines = 0; m_gen = 0; m_stale = 0;
      foreach (m_board[i]) m_board[i] = 0;
      return;
    end
    case (m_ph)
      P_SPAWN: begin
        m_piece = m_gen; m_gen = (m_gen + 1) % 7;
        m_x = 4; m_y = 0; m_rot = 0; m_timer = 0; m_drop = 0;
        m_ph = P_CHECK;
      end
      P_CHECK: begin
        m_stale = 1;
        m_ph = (occ(b1) || occ(b2) || occ(b3) || occ(b4)) ? P_OVER : P_ACT;
      end
      P_ACT: begin
        m_key = keycode;
        m_timer = (m_timer + 1) % 8;
        m_kat = 0;
        if (m_stale) m_stale = 0;
        else if (int'(ty) != m_y) begin
          if (ti || ty == 0) m_ph = P_LOCK;
          else begin m_y = ty; m_drop = td; m_stale = 1; end
        end else if (int'(tx) != m_x || int'(tr) != m_rot) begin
          if (!ti && int'(tx) + int'(tw) <= 10 && m_y + int'(th) <= 22) begin
            m_x = tx; m_rot = tr; m_kat = 1; m_stale = 1;
          end
        end else m_drop = td;
      end
      P_LOCK: model_lock();
      P_CLEAR: begin
        m_left--;
        if (m_left == 0) m_ph = P_SPAWN;
      end
      default: m_key = keycode;
    endcase
  endtask

  task automatic cycle();
    @(posedge frame_clk);
    #1;
    model_step();
    check("cur_pos_x", cur_pos_x, m_x);
    check("cur_pos_y", cur_pos_y, m_y);
    check("cur_rot", cur_rot, m_rot);
    check("cur_piece", cur_piece, m_piece);
    check("timer", timer, m_timer);
    check("drop_mode", drop_mode, m_drop);
    check("last_keycode", last_keycode, m_key);
    check("key_action_taken", key_action_taken, m_kat);
    check("game_over", game_over, m_ph == P_OVER);
    if (m_ph != P_CLEAR) begin
      check("fallen_pieces", fallen_pieces, packed_board());
      check("lines_cleared", lines_cleared, m_lines);
    end
  endtask

  task automatic neutral();
    tx = 4'(m_x); ty = 5'(m_y); tr = 2'(m_rot); ti = 0; td = 0; tw = 1; th = 1;
    b1 = 8'hFF; b2 = 8'hFF; b3 = 8'hFF; b4 = 8'hFF;
  endtask

  task automatic wait_active();
    for (int i = 0; i < 100 && !(m_ph == P_ACT && !m_stale); i++) begin
      neutral();
      cycle();
    end
    check("wait_active", m_ph == P_ACT && !m_stale, 1);
    neutral();
  endtask

  task automatic lock_at(input logic [7:0] c1, c2, c3, c4);
    wait_active();
    ty = 5'(m_y + 1); ti = 1;
    b1 = c1; b2 = c2; b3 = c3; b4 = c4;
    cycle();
    ti = 0;
    cycle();
    wait_active();
  endtask

  initial begin
    logic [219:0] exp_board;
    repeat (3) cycle();
    Reset = 1;
    cycle();
    check("spawn_x", cur_pos_x, 4);
    cycle();
    cycle();
    check("active_piece", cur_piece, 0);
    wait_active();
    tx = 3; tw = 2; th = 1;
    cycle();
    check("move_left_x", cur_pos_x, 3);
    check("move_left_kat", key_action_taken, 1);
    tx = 0; tw = 1;
    cycle();
    check("stale_ignored_x", cur_pos_x, 3);
    wait_active();
    tx = 9; tw = 2;
    cycle();
    check("reject_x", cur_pos_x, 3);
    check("reject_kat", key_action_taken, 0);
    wait_active();
    ty = 5;
    cycle();
    lock_at(60, 61, 62, 63);
    check("piece_after_lock", cur_piece, 1);
    check("bits_60_63", fallen_pieces[63:60], 4'hF);
    lock_at(210, 211, 212, 213);
    lock_at(214, 215, 216, 217);
    lock_at(218, 8'hFF, 8'hFF, 8'hFF);
    lock_at(219, 8'hFF, 8'hFF, 8'hFF);
    check("row21_lines", lines_cleared, 1);
    exp_board = '0;
    exp_board[73:70] = 4'hF;
    check("row21_shift", fallen_pieces, exp_board);
    wait_active();
    ty = 5'(m_y + 1); ti = 1; b1 = 44;
    cycle();
    ti = 0;
    for (int i = 0; i < 40 && m_ph != P_OVER; i++) cycle();
    check("gameover_reached", game_over, 1);
    repeat (5) begin
      keycode = 8'($urandom);
      cycle();
    end
    check("gameover_held", game_over, 1);
    Reset = 0;
    cycle();
    Reset = 1;
    check("gameover_reset", game_over, 0);
    neutral();
    for (int n = 0; n < 4000; n++) begin
      keycode = 8'($urandom);
      case ($urandom_range(0, 5))
        0: ty = 5'(m_y + 1);
        1: ty = 0;
        2: ty = 5'($urandom);
        default: ty = 5'(m_y);
      endcase
      tx = $urandom_range(0, 1) ? 4'($urandom) : 4'(m_x);
      tr = $urandom_range(0, 1) ? 2'($urandom) : 2'(m_rot);
      ti = $urandom_range(0, 3) == 0;
      td = 1'($urandom);
      tw = 3'($urandom_range(1, 4));
      th = 3'($urandom_range(1, 4));
      b1 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(140, 230));
      b2 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(140, 230));
      b3 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(140, 230));
      b4 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(140, 230));
      Reset = !((m_ph == P_OVER && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
